// File: rtl/keyled_cpu_jtag_scan_master.sv
// keyled_cpu_jtag_scan_master: JTAG scan master that runs an optional IR scan followed by a DR scan
// Ports: clk/reset_n (sync, active-low); cmd_valid/cmd_ready/cmd_ir_en/cmd_ir/cmd_dr command in;
//        rsp_valid/rsp_ready/rsp_dr captured DR response out; tck/tms/tdi/tdo target TAP pins.
// Build option: KEYLED_JTAG_SCAN_LOOPBACK_EN adds input loopback, which samples our own tdi instead of tdo.
module keyled_cpu_jtag_scan_master #(
  parameter int CLK_DIV  = 2,
  parameter int IR_WIDTH = 10,
  parameter int DR_WIDTH = 38
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_ir_en,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic                tck,
  output logic                tms,
  output logic                tdi,
  input  logic                tdo
`ifdef KEYLED_JTAG_SCAN_LOOPBACK_EN
  ,
  input  logic                loopback
`endif
);
  localparam int MW = (IR_WIDTH > DR_WIDTH ? IR_WIDTH : DR_WIDTH) > 6 ? (IR_WIDTH > DR_WIDTH ? IR_WIDTH : DR_WIDTH) : 6;
  localparam int IW = $clog2(MW + 1);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  // Each state names the TAP state the target sits in while the current TCK period runs.
  typedef enum logic [3:0] {
    TLR_SEQ, IDLE, SEL_DR, SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, UPD_IR,
    CAP_DR, SHIFT_DR, EXIT1_DR, UPD_DR, RESP
  } state_t;
  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
  logic                ir_pend_q, ir_pend_d;
  logic [IR_WIDTH-1:0] ir_sh_q, ir_sh_d;
  logic [DR_WIDTH-1:0] dr_sh_q, dr_sh_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DR_WIDTH-1:0] rsp_dr_q, rsp_dr_d;
  logic                half_end, smp;
`ifdef KEYLED_JTAG_SCAN_LOOPBACK_EN
  assign smp = loopback ? tdi_q : tdo;
`else
  assign smp = tdo;
`endif
  assign half_end  = busy_q && cnt_q == CW'(CLK_DIV - 1);
  assign cmd_ready = state_q == IDLE && !busy_q && !rsp_valid_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dr    = rsp_dr_q;
  assign tck       = tck_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    ir_pend_d   = ir_pend_q;
    ir_sh_d     = ir_sh_q;
    dr_sh_d     = dr_sh_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dr_d    = rsp_dr_q;
    if (busy_q) cnt_d = half_end ? '0 : cnt_q + 1'b1;
    // Rising tck: the only point where the target's tdo is sampled; DR bits enter from the top.
    if (half_end && !tck_q) begin
      tck_d = 1'b1;
      if (state_q == SHIFT_DR) rsp_dr_d = DR_WIDTH'({smp, rsp_dr_q} >> 1);
    end
    // End of a period: advance the TAP walk and, if another period follows, start it on this same edge.
    if (half_end && tck_q) begin
      tck_d = 1'b0;
      case (state_q)
        TLR_SEQ:  state_d = idx_q == IW'(5) ? IDLE : TLR_SEQ;
        IDLE:     state_d = SEL_DR;
        SEL_DR:   state_d = ir_pend_q ? SEL_IR : CAP_DR;
        SEL_IR:   state_d = CAP_IR;
        CAP_IR:   state_d = SHIFT_IR;
        SHIFT_IR: state_d = idx_q == IW'(IR_WIDTH - 1) ? EXIT1_IR : SHIFT_IR;
        EXIT1_IR: state_d = UPD_IR;
        UPD_IR:   state_d = SEL_DR;
        CAP_DR:   state_d = SHIFT_DR;
        SHIFT_DR: state_d = idx_q == IW'(DR_WIDTH - 1) ? EXIT1_DR : SHIFT_DR;
        EXIT1_DR: state_d = UPD_DR;
        default:  state_d = RESP;
      endcase
      idx_d = state_d == state_q ? idx_q + 1'b1 : '0;
      if (state_q == SHIFT_IR) ir_sh_d = ir_sh_q >> 1;
      if (state_q == SHIFT_DR) dr_sh_d = dr_sh_q >> 1;
      if (state_q == SEL_DR) ir_pend_d = 1'b0;
      busy_d      = state_d != IDLE && state_d != RESP;
      rsp_valid_d = state_d == RESP;
      if (busy_d) begin
        tms_d = state_d == TLR_SEQ  ? idx_d != IW'(5) :
                state_d == SEL_DR   ? ir_pend_q :
                state_d == SHIFT_IR ? idx_d == IW'(IR_WIDTH - 1) :
                state_d == SHIFT_DR ? idx_d == IW'(DR_WIDTH - 1) :
                state_d inside {EXIT1_IR, UPD_IR, EXIT1_DR};
        tdi_d = state_d == SHIFT_IR ? ir_sh_d[0] : state_d == SHIFT_DR ? dr_sh_d[0] : 1'b0;
      end
    end
    // RESP lingers one cycle after rsp_valid drops so a new command cannot land on the clearing cycle.
    if (state_q == RESP) begin
      rsp_valid_d = rsp_valid_q && !rsp_ready;
      if (!rsp_valid_q) state_d = IDLE;
    end
    // Acceptance starts the Run-Test/Idle -> Select-DR period immediately.
    if (cmd_ready && cmd_valid) begin
      busy_d    = 1'b1;
      cnt_d     = '0;
      tck_d     = 1'b0;
      tms_d     = 1'b1;
      tdi_d     = 1'b0;
      ir_pend_d = cmd_ir_en;
      ir_sh_d   = cmd_ir;
      dr_sh_d   = cmd_dr;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= TLR_SEQ;
      busy_q      <= 1'b1;
      cnt_q       <= '0;
      idx_q       <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      ir_pend_q   <= 1'b0;
      ir_sh_q     <= '0;
      dr_sh_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dr_q    <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      ir_pend_q   <= ir_pend_d;
      ir_sh_q     <= ir_sh_d;
      dr_sh_q     <= dr_sh_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dr_q    <= rsp_dr_d;
    end
  end
endmodule

// File: tb/tb_keyled_cpu_jtag_scan_master.sv
// tb_keyled_cpu_jtag_scan_master: scoreboard bench with an echo TAP model and per-period tms/tdi trace
module tb_keyled_cpu_jtag_scan_master;
  localparam int IRW = 10;
  localparam int DRW = 38;
  localparam int DIV = 2;
  logic clk = 0, reset_n = 0, cmd_valid = 0, cmd_ir_en = 0, rsp_ready = 0, tdo = 0;
  logic cmd_ready, rsp_valid, tck, tms, tdi;
  logic [IRW-1:0] cmd_ir = '0;
  logic [DRW-1:0] cmd_dr = '0;
  logic [DRW-1:0] rsp_dr;
`ifdef KEYLED_JTAG_SCAN_LOOPBACK_EN
  logic loopback = 0;
`endif
  int n_cmp = 0, n_err = 0;
  logic [DRW-1:0] sb[$];
  logic [127:0] exp_tms, exp_tdi, got_tms, got_tdi;
  int exp_n = 0, got_n = 0, hi_len = 0;
  logic tck_p = 0;
  keyled_cpu_jtag_scan_master #(.CLK_DIV(DIV), .IR_WIDTH(IRW), .DR_WIDTH(DRW)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir_en(cmd_ir_en), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_dr(rsp_dr), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
`ifdef KEYLED_JTAG_SCAN_LOOPBACK_EN
    , .loopback(loopback)
`endif
  );
  always #5 clk = ~clk;
  // Target model: tdo presents the tdi bit of the previous TCK period.
  always @(posedge tck) tdo <= tdi;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic add_per(input logic m, input logic d);
    exp_tms[exp_n] = m;
    exp_tdi[exp_n] = d;
    exp_n++;
  endtask
  always @(posedge clk) begin
    #1;
    if (tck && !tck_p && got_n < 128) begin
      got_tms[got_n] = tms;
      got_tdi[got_n] = tdi;
      got_n++;
    end
    if (tck) hi_len++;
    else begin
      if (tck_p && reset_n) chk("tck_hi", hi_len, DIV);
      hi_len = 0;
    end
    tck_p = tck;
  end
  task automatic do_reset(input int hold);
    int ones = 0, zeros = 0, rises = 0, n = 0;
    logic p = 0, saw_rsp = 0;
    reset_n = 0;
    repeat (hold) @(posedge clk);
    #2;
    chk("rst_tck", tck, 0);
    chk("rst_tms", tms, 1);
    chk("rst_tdi", tdi, 0);
    chk("rst_rdy", cmd_ready, 0);
    chk("rst_rspv", rsp_valid, 0);
    chk("rst_rspdr", rsp_dr, 0);
    reset_n = 1;
    while (!cmd_ready && n < 200) begin
      if (tms) ones++;
      else zeros++;
      if (tck && !p) rises++;
      p = tck;
      saw_rsp |= rsp_valid;
      n++;
      @(posedge clk);
      #2;
    end
    chk("tlr_ones", ones, 20);
    chk("tlr_zeros", zeros, 4);
    chk("tlr_rises", rises, 6);
    chk("tlr_ready", cmd_ready, 1);
    chk("tlr_norsp", saw_rsp, 0);
  endtask
  task automatic run_scan(input logic ir_en, input logic [IRW-1:0] ir, input logic [DRW-1:0] dr,
                          input int hold, input logic lb);
    int n = 0, s;
    logic ok = 1;
    logic [DRW-1:0] held;
    exp_n = 0;
    exp_tms = '0;
    exp_tdi = '0;
    add_per(1, 0);
    if (ir_en) begin
      add_per(1, 0); add_per(0, 0); add_per(0, 0);
      for (int i = 0; i < IRW; i++) add_per(i == IRW - 1, ir[i]);
      add_per(1, 0); add_per(1, 0); add_per(0, 0); add_per(0, 0);
    end else begin
      add_per(0, 0); add_per(0, 0);
    end
    s = exp_n;
    for (int i = 0; i < DRW; i++) add_per(i == DRW - 1, dr[i]);
    add_per(1, 0); add_per(0, 0);
    for (int i = 0; i < DRW; i++) held[i] = exp_tdi[s + i - 1];
    sb.push_back(lb ? dr : held);
`ifdef KEYLED_JTAG_SCAN_LOOPBACK_EN
    loopback = lb;
`endif
    got_n = 0;
    got_tms = '0;
    got_tdi = '0;
    cmd_ir_en = ir_en;
    cmd_ir = ir;
    cmd_dr = dr;
    cmd_valid = 1;
    while (!cmd_ready && n < 100) begin @(posedge clk); #1; n++; end
    chk("acc_wait", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 0;
    cmd_ir = IRW'($urandom);
    cmd_dr = DRW'({$urandom, $urandom});
    cmd_ir_en = ~ir_en;
    chk("rdy_drop", cmd_ready, 0);
    n = 0;
    while (!rsp_valid && n < 2000) begin @(posedge clk); #1; n++; end
    chk("rsp_wait", rsp_valid, 1);
    held = rsp_dr;
    cmd_valid = hold > 0;
    repeat (hold) begin
      @(posedge clk);
      #1;
      ok &= rsp_valid && rsp_dr == held && !cmd_ready;
    end
    if (hold > 0) chk("rsp_hold", ok, 1);
    cmd_valid = 0;
    rsp_ready = 1;
    chk("rsp_dr", rsp_dr, sb.pop_front());
    chk("n_per", got_n, exp_n);
    chk("tms_seq", got_tms, exp_tms);
    chk("tdi_seq", got_tdi, exp_tdi);
    @(posedge clk);
    #1;
    rsp_ready = 0;
    chk("rsp_clr", rsp_valid, 0);
    chk("rdy_gap", cmd_ready, 0);
    @(posedge clk);
    #1;
    chk("rdy_back", cmd_ready, 1);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int n = 0;
    do_reset(3);
    run_scan(0, '0, 38'h2A_5A5A_5A5A, 5, 0);
    run_scan(1, 10'h00E, '0, 0, 0);
    run_scan(0, '0, 38'h15_A5A5_A5A5, 100, 0);
    repeat (3) run_scan(1'($urandom_range(0, 1)), IRW'($urandom), DRW'({$urandom, $urandom}), $urandom_range(0, 3), 0);
    got_n = 0;
    cmd_ir_en = 1;
    cmd_ir = IRW'($urandom);
    cmd_dr = DRW'({$urandom, $urandom});
    cmd_valid = 1;
    @(posedge clk);
    #1;
    cmd_valid = 0;
    while (got_n < 20 && n < 500) begin @(posedge clk); #1; n++; end
    chk("mid_wait", got_n >= 20, 1);
    do_reset(1);
    run_scan(1, 10'h3FF, 38'h00_FFFF_0000, 2, 0);
`ifdef KEYLED_JTAG_SCAN_LOOPBACK_EN
    run_scan(0, '0, 38'h3F_0000_FFFF, 0, 1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
